// File: rtl/logic_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_cfg_pkg
// Brief    : Shared types and constants for the logic-array config loader.
// Revision : 1.0 - initial release
// ============================================================================
package logic_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } cfg_state_t;

    localparam int CFG_W         = 4;
    localparam int CFG_STATE_BIT = 3;
    localparam int CFG_RAM_MSB   = 1;
    localparam int CFG_RAM_LSB   = 0;

    localparam logic [1:0] MODE_NULL = 2'b00;
    localparam logic [1:0] MODE_IN0  = 2'b01;
    localparam logic [1:0] MODE_IN1  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cfg_onehot_strobe.sv
`default_nettype none
// ============================================================================
// Module   : cfg_onehot_strobe
// Brief    : Registered one-hot write strobe; bit idx is high for the cycle
//            after fire, every bit low otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_onehot_strobe #(
    parameter int NUM_CELLS = 16,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 fire,
    output logic [NUM_CELLS-1:0] write_en
);

    // One flop per bit, each decoded directly from idx, so no glitch can reach a cell.
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_bit
        localparam logic [IDX_W-1:0] c_idx = IDX_W'(i);
        always_ff @(posedge clk) begin
            if (rst) begin
                write_en[i] <= 1'b0;
            end else begin
                write_en[i] <= fire && (idx == c_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_array_config.sv
`default_nettype none
// ============================================================================
// Module   : logic_array_config
// Brief    : Sequential config loader for a 1-D logic_block array.
//            Optional macro CFG_PARITY_EN adds an odd-parity check on cfg_data.
// Revision : 1.0 - initial release
// ============================================================================
module logic_array_config
    import logic_cfg_pkg::*;
#(
    parameter  int NUM_CELLS    = 16,
    parameter  int SETUP_CYCLES = 1,
    localparam int IDX_W        = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CFG_W-1:0]     cfg_data,
`ifdef CFG_PARITY_EN
    input  logic                 cfg_parity,
`endif
    output logic [CFG_W-1:0]     cell_ram,
    output logic [NUM_CELLS-1:0] cell_write_en,
    output logic [IDX_W-1:0]     cell_idx,
    output logic                 eval_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int c_cnt_w = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    cfg_state_t           r_state;
    logic [c_cnt_w-1:0]   r_setup_cnt;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_last;
    logic                 w_word_ok;

    assign w_accept = cfg_valid && cfg_ready;
    assign w_fire   = (r_state == ST_SETUP) && (r_setup_cnt == c_cnt_w'(SETUP_CYCLES - 1));
    assign w_last   = (cell_idx == IDX_W'(NUM_CELLS - 1));

`ifdef CFG_PARITY_EN
    assign w_word_ok = ^{cfg_data, cfg_parity};
    assign err       = r_err;
`else
    assign w_word_ok = 1'b1;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_setup_cnt <= '0;
            r_err       <= 1'b0;
            cell_ram    <= '0;
            cell_idx    <= '0;
            cfg_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            eval_en     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_LOAD;
                        cell_idx  <= '0;
                        r_err     <= 1'b0;
                        eval_en   <= 1'b0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        cell_ram  <= cfg_data;
                        cfg_ready <= 1'b0;
                        if (w_word_ok) begin
                            r_state     <= ST_SETUP;
                            r_setup_cnt <= '0;
                        end else begin
                            // Bad word aborts the load; remaining cells stay untouched.
                            r_err   <= 1'b1;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_fire) begin
                        r_state <= ST_STROBE;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + 1'b1;
                    end
                end
                ST_STROBE: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        cell_idx  <= cell_idx + 1'b1;
                        cfg_ready <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    eval_en <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    cfg_onehot_strobe #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .idx      (cell_idx),
        .fire     (w_fire),
        .write_en (cell_write_en)
    );

endmodule
`default_nettype wire

// File: tb/tb_logic_array_config.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_array_config
// Brief    : Directed self-checking bench for logic_array_config (4 cells).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_array_config;

    localparam int NUM_CELLS = 4;
    localparam int IDX_W     = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [3:0]           cfg_data;
`ifdef CFG_PARITY_EN
    logic                 cfg_parity;
`endif
    logic [3:0]           cell_ram;
    logic [NUM_CELLS-1:0] cell_write_en;
    logic [IDX_W-1:0]     cell_idx;
    logic                 eval_en;
    logic                 busy;
    logic                 done;
    logic                 err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_array_config #(
        .NUM_CELLS    (NUM_CELLS),
        .SETUP_CYCLES (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
`ifdef CFG_PARITY_EN
        .cfg_parity    (cfg_parity),
`endif
        .cell_ram      (cell_ram),
        .cell_write_en (cell_write_en),
        .cell_idx      (cell_idx),
        .eval_en       (eval_en),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 4'h0;
`ifdef CFG_PARITY_EN
        cfg_parity = 1'b0;
`endif
        repeat (3) step();
        checks++;
        if ({cfg_ready, busy, done, err, eval_en} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags got rdy/busy/done/err/eval=%b want 00001",
                     {cfg_ready, busy, done, err, eval_en});
        end
        checks++;
        if (cell_write_en !== 4'b0000 || cell_ram !== 4'h0 || cell_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_bus got we=%b ram=%h idx=%0d want 0000/0/0",
                     cell_write_en, cell_ram, cell_idx);
        end
        rst = 1'b0;
        step();
    endtask

    // Full 4-cell load; stall_len cycles of cfg_valid=0 in cell stall_cell's LOAD,
    // optional extra start pulses at cycles 4 and 9. Cycle 0 is the start cycle.
    task automatic run_load(input string name, input int stall_cell, input int stall_len,
                            input bit extra_starts);
        logic [3:0] data [4];
        int         strobe_c [4];
        int         done_c;
        int         cur;
        bit         in_stall;
        logic [3:0] exp_we;
        data[0] = 4'h1; data[1] = 4'h2; data[2] = 4'h3; data[3] = 4'h8;
        for (int k = 0; k < 4; k++)
            strobe_c[k] = 3 + 4 * k + ((stall_cell >= 0 && k >= stall_cell) ? stall_len : 0);
        done_c = 17 + stall_len;
        cur    = 0;
        for (int c = 0; c <= done_c + 1; c++) begin
            if (cur < 3 && c == strobe_c[cur] + 1) cur++;
            in_stall = (stall_cell >= 0) && (c >= strobe_c[stall_cell] - 2 - stall_len)
                       && (c < strobe_c[stall_cell] - 2);
            exp_we = 4'b0000;
            for (int k = 0; k < 4; k++) if (c == strobe_c[k]) exp_we[k] = 1'b1;
            checks++;
            if (cell_write_en !== exp_we) begin
                errors++;
                $display("FAIL %s_we c%0d got %b want %b", name, c, cell_write_en, exp_we);
            end
            if (exp_we != 4'b0000) begin
                checks++;
                if (cell_ram !== data[cur] || cell_idx !== IDX_W'(cur)) begin
                    errors++;
                    $display("FAIL %s_ram c%0d got ram=%h idx=%0d want ram=%h idx=%0d",
                             name, c, cell_ram, cell_idx, data[cur], cur);
                end
            end
            checks++;
            if (done !== (c == done_c)) begin
                errors++;
                $display("FAIL %s_done c%0d got %b want %b", name, c, done, (c == done_c));
            end
            checks++;
            if (eval_en !== (c == 0 || c > done_c) || busy !== (c >= 1 && c <= done_c)) begin
                errors++;
                $display("FAIL %s_eval_busy c%0d got eval=%b busy=%b want eval=%b busy=%b",
                         name, c, eval_en, busy, (c == 0 || c > done_c), (c >= 1 && c <= done_c));
            end
            if (c >= 1) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_err c%0d got %b want 0", name, c, err);
                end
            end
            if (in_stall) begin
                checks++;
                if (cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_stall_ready c%0d got %b want 1", name, c, cfg_ready);
                end
            end
            start     = (c == 0) || (extra_starts && (c == 4 || c == 9));
            cfg_valid = !in_stall;
            cfg_data  = data[cur];
`ifdef CFG_PARITY_EN
            cfg_parity = ~^data[cur];
`endif
            step();
        end
        start = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic test_basic_load();
        run_load("basic", -1, 0, 1'b0);
    endtask

    task automatic test_valid_stall();
        run_load("stall", 2, 10, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_load("busy_start", -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 4'h5;
`ifdef CFG_PARITY_EN
        cfg_parity = ~^cfg_data;
`endif
        step();
        start = 1'b0;
        repeat (6) step();
        // Now in cycle 7: STROBE of cell 1.
        checks++;
        if (cell_write_en !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_strobe got %b want 0010", cell_write_en);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; cfg_valid = 1'b0;
        checks++;
        if (cell_write_en !== 4'b0000 || busy !== 1'b0 || eval_en !== 1'b1 || done !== 1'b0
            || cell_idx !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_after got we=%b busy=%b eval=%b done=%b idx=%0d want 0000/0/1/0/0",
                     cell_write_en, busy, eval_en, done, cell_idx);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_idle%0d got done=%b busy=%b want 0/0", i, done, busy);
            end
        end
        run_load("reload", -1, 0, 1'b0);
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity_abort();
        logic [3:0] data [4];
        int         cur;
        data[0] = 4'h1; data[1] = 4'h2; data[2] = 4'h3; data[3] = 4'h8;
        cur = 0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 4 || c == 8) cur++;
            checks++;
            if (cell_write_en !== ((c == 3) ? 4'b0001 : (c == 7) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL parity_we c%0d got %b", c, cell_write_en);
            end
            checks++;
            if (done !== (c == 10) || (c >= 1 && err !== (c >= 10))) begin
                errors++;
                $display("FAIL parity_done_err c%0d got done=%b err=%b want done=%b err=%b",
                         c, done, err, (c == 10), (c >= 10));
            end
            checks++;
            if (eval_en !== (c == 0 || c > 10)) begin
                errors++;
                $display("FAIL parity_eval c%0d got %b want %b", c, eval_en, (c == 0 || c > 10));
            end
            start     = (c == 0);
            cfg_valid = (c < 11);
            cfg_data  = data[cur];
            // 4'h3 has an even bit count, so parity 0 makes the word bad.
            cfg_parity = (cur == 2) ? 1'b0 : ~^data[cur];
            step();
        end
        cfg_valid = 1'b0;
        run_load("after_parity", -1, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_valid_stall();
        test_start_while_busy();
        test_reset_mid_load();
`ifdef CFG_PARITY_EN
        test_parity_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
